// File: rtl/microprogram_sequencer_if.sv
// Bus bundle between the microprogram sequencer and its driver: store load port,
// datapath status flags, control word and run status.
interface microprogram_sequencer_if #(
    parameter int CW_WIDTH   = 55,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
);
    localparam int IW = CW_WIDTH + ADDR_WIDTH + 3;

    logic                  start;
    logic                  load_en;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [IW-1:0]         load_data;
    logic                  V;
    logic                  C;
    logic                  N;
    logic                  Z;
    logic [CW_WIDTH-1:0]   ControlWord;
    logic [ADDR_WIDTH-1:0] car;
    logic                  busy;
    logic                  done;
    logic [CNT_WIDTH-1:0]  cycles;

    modport master (
        output start, load_en, load_addr, load_data, V, C, N, Z,
        input  ControlWord, car, busy, done, cycles
    );

    modport slave (
        input  start, load_en, load_addr, load_data, V, C, N, Z,
        output ControlWord, car, busy, done, cycles
    );
endinterface

// File: rtl/microprogram_sequencer.sv
// Microprogrammed control unit: writable control store, CAR sequencing with
// flag-conditional branches, and a saturating RUN-cycle counter.
module microprogram_sequencer #(
    parameter int CW_WIDTH   = 55,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    microprogram_sequencer_if.slave  bus
);
    localparam int IW    = CW_WIDTH + ADDR_WIDTH + 3;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t                state_q;
    logic [IW-1:0]         mem_q [DEPTH];
    logic [IW-1:0]         ir_q;
    logic [ADDR_WIDTH-1:0] car_q;
    logic [ADDR_WIDTH-1:0] car_d;
    logic [CNT_WIDTH-1:0]  cycles_q;
    logic                  busy_q;
    logic                  done_q;

    logic [2:0]            sel;
    logic [ADDR_WIDTH-1:0] na;
    logic                  take;

    assign sel = ir_q[IW-1 -: 3];
    assign na  = ir_q[CW_WIDTH +: ADDR_WIDTH];

    always_comb begin
        take = 1'b0;
        unique case (sel)
            3'b001:  take = 1'b1;
            3'b010:  take = bus.Z;
            3'b011:  take = bus.N;
            3'b100:  take = bus.C;
            3'b101:  take = bus.V;
            3'b110:  take = ~bus.Z;
            default: take = 1'b0;
        endcase
        car_d = take ? na : car_q + ADDR_WIDTH'(1);
    end

    // Store has no reset so a program survives rst_n; writes are locked out in
    // RUN and on a start edge so the fetch of mem[0] never races a write.
    always_ff @(posedge clk) begin
        if (bus.load_en && (state_q != RUN) && !bus.start)
            mem_q[bus.load_addr] <= bus.load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            car_q    <= '0;
            ir_q     <= '0;
            cycles_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, HALT: begin
                    if (bus.start) begin
                        state_q  <= RUN;
                        car_q    <= '0;
                        ir_q     <= mem_q[0];
                        cycles_q <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                RUN: begin
                    if (cycles_q != '1)
                        cycles_q <= cycles_q + CNT_WIDTH'(1);
                    if (sel == 3'b111) begin
                        state_q <= HALT;
                        ir_q    <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        car_q <= car_d;
                        ir_q  <= mem_q[car_d];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ControlWord = busy_q ? ir_q[CW_WIDTH-1:0] : '0;
    assign bus.car         = car_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cycles      = cycles_q;
endmodule
